// File: rtl/decode_issue_pkg.sv
// Shared definitions for the decode/issue stage: widths, instruction field
// positions, opcode and ALU operation encodings, and the issued-operation record.
package decode_issue_pkg;

    localparam int XLEN = 32;
    localparam int RAW  = 5;

    localparam int OPC_LSB = 27;
    localparam int RD_LSB  = 22;
    localparam int RS_LSB  = 17;
    localparam int RT_LSB  = 12;
    localparam int SH_LSB  = 7;
    localparam int AOP_LSB = 2;
    localparam int IMM_W   = 17;

    localparam logic [RAW-1:0] OPC_RTYPE = 5'b00000;
    localparam logic [RAW-1:0] OPC_ADDI  = 5'b00101;

    localparam logic [RAW-1:0] ALU_ADD = 5'b00000;
    localparam logic [RAW-1:0] ALU_SUB = 5'b00001;
    localparam logic [RAW-1:0] ALU_AND = 5'b00010;
    localparam logic [RAW-1:0] ALU_OR  = 5'b00011;
    localparam logic [RAW-1:0] ALU_SLL = 5'b00100;
    localparam logic [RAW-1:0] ALU_SRA = 5'b00101;

    typedef struct packed {
        logic [XLEN-1:0] op_a;
        logic [XLEN-1:0] op_b;
        logic [RAW-1:0]  alu_op;
        logic [RAW-1:0]  shamt;
        logic [RAW-1:0]  rd;
        logic            rd_we;
        logic            illegal;
    } issue_t;

    function automatic logic aluop_legal(input logic [RAW-1:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_AND) ||
               (op == ALU_OR)  || (op == ALU_SLL) || (op == ALU_SRA);
    endfunction

    function automatic logic [XLEN-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/decode_issue_reg_scoreboard.sv
// Per-register busy bits: set marks a pending write, clear retires it.
// Register 0 is never busy; a same-cycle set and clear of one bit leaves it set.
module reg_scoreboard
    import decode_issue_pkg::*;
(
    input  logic           clock,
    input  logic           reset,
    input  logic           set_en,
    input  logic [RAW-1:0] set_addr,
    input  logic           clr_en,
    input  logic [RAW-1:0] clr_addr,
    input  logic [RAW-1:0] qa_addr,
    input  logic [RAW-1:0] qb_addr,
    output logic           qa_busy,
    output logic           qb_busy
);

    logic [XLEN-1:0] busy_q;
    logic [XLEN-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_addr] = 1'b0;
        end
        if (set_en) begin
            busy_d[set_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign qa_busy = busy_q[qa_addr];
    assign qb_busy = busy_q[qb_addr];

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage: decodes R-type and addi, selects operands with optional
// writeback bypass, stalls on scoreboard hazards and holds one issued operation.
module decode_issue
    import decode_issue_pkg::*;
#(
    parameter bit FWD_EN = 1'b1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] instr,
    output logic [RAW-1:0]  rf_rs_addr,
    output logic [RAW-1:0]  rf_rt_addr,
    input  logic [XLEN-1:0] rf_rs_data,
    input  logic [XLEN-1:0] rf_rt_data,
    input  logic            wb_en,
    input  logic [RAW-1:0]  wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] op_a,
    output logic [XLEN-1:0] op_b,
    output logic [RAW-1:0]  alu_op,
    output logic [RAW-1:0]  shamt,
    output logic [RAW-1:0]  rd,
    output logic            rd_we,
    output logic            illegal
);

    logic [RAW-1:0]  opcode_f, rd_f, rs_f, rt_f, shamt_f, aluop_f;
    logic            is_rtype, is_addi, legal;
    logic            rs_fwd, rt_fwd, rs_busy, rt_busy, hazard, accept;
    logic [XLEN-1:0] rs_val, rt_val;
    issue_t          dec;
    issue_t          issue_q, issue_d;
    logic            out_valid_q, out_valid_d;

    assign opcode_f = instr[OPC_LSB +: RAW];
    assign rd_f     = instr[RD_LSB  +: RAW];
    assign rs_f     = instr[RS_LSB  +: RAW];
    assign rt_f     = instr[RT_LSB  +: RAW];
    assign shamt_f  = instr[SH_LSB  +: RAW];
    assign aluop_f  = instr[AOP_LSB +: RAW];

    assign rf_rs_addr = rs_f;
    assign rf_rt_addr = rt_f;

    always_comb begin
        is_rtype = (opcode_f == OPC_RTYPE);
        is_addi  = (opcode_f == OPC_ADDI);
        legal    = is_addi || (is_rtype && aluop_legal(aluop_f));

        rs_fwd = FWD_EN && wb_en && (wb_rd == rs_f) && (rs_f != '0);
        rt_fwd = FWD_EN && wb_en && (wb_rd == rt_f) && (rt_f != '0);
        rs_val = (rs_f == '0) ? '0 : (rs_fwd ? wb_data : rf_rs_data);
        rt_val = (rt_f == '0) ? '0 : (rt_fwd ? wb_data : rf_rt_data);

        // Illegal operations read nothing, so they never wait on the scoreboard.
        hazard = legal && ((rs_busy && !rs_fwd) || (is_rtype && rt_busy && !rt_fwd));

        dec = '0;
        if (legal) begin
            dec.op_a  = rs_val;
            dec.rd    = rd_f;
            dec.rd_we = (rd_f != '0);
            if (is_rtype) begin
                dec.op_b   = rt_val;
                dec.alu_op = aluop_f;
                dec.shamt  = shamt_f;
            end else begin
                dec.op_b   = sext_imm(instr[IMM_W-1:0]);
                dec.alu_op = ALU_ADD;
            end
        end else begin
            dec.illegal = 1'b1;
        end
    end

    assign in_ready = !reset && (!out_valid_q || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;

    always_comb begin
        issue_d     = issue_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            issue_d     = dec;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            issue_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            issue_q     <= issue_d;
            out_valid_q <= out_valid_d;
        end
    end

    reg_scoreboard u_scoreboard (
        .clock    (clock),
        .reset    (reset),
        .set_en   (accept && dec.rd_we),
        .set_addr (dec.rd),
        .clr_en   (wb_en && (wb_rd != '0)),
        .clr_addr (wb_rd),
        .qa_addr  (rs_f),
        .qb_addr  (rt_f),
        .qa_busy  (rs_busy),
        .qb_busy  (rt_busy)
    );

    assign out_valid = out_valid_q;
    assign op_a      = issue_q.op_a;
    assign op_b      = issue_q.op_b;
    assign alu_op    = issue_q.alu_op;
    assign shamt     = issue_q.shamt;
    assign rd        = issue_q.rd;
    assign rd_we     = issue_q.rd_we;
    assign illegal   = issue_q.illegal;

endmodule
